// File: rtl/bus_timeout_ctrl_pkg.sv
// Shared definitions for the 68000 bus-error watchdog: widths, register bit map, FSM states.
package bus_timeout_ctrl_pkg;

  localparam int unsigned LIMIT_W = 10;
  localparam int unsigned ADDR_W  = 23;
  localparam int unsigned FC_W    = 3;
  localparam int unsigned CTRL_W  = 16;

  // ctrl_in bit positions (also used by the bus_ctrl decode)
  localparam int unsigned CTRL_EN_BIT    = 15;
  localparam int unsigned CTRL_CLR_BIT   = 14;
  localparam int unsigned CTRL_INTEN_BIT = 13;

  // status_out bit positions
  localparam int unsigned STAT_EN_BIT    = 15;
  localparam int unsigned STAT_INTEN_BIT = 13;
  localparam int unsigned STAT_FAULT_BIT = 12;
  localparam int unsigned STAT_OVR_BIT   = 11;
  localparam int unsigned STAT_FWR_BIT   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_BERR  = 2'd2,
    ST_TERM  = 2'd3
  } state_t;

  // Snapshot of a bus cycle: address, function code, write flag (1 = write)
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [FC_W-1:0]   fc;
    logic              wr;
  } cycle_info_t;

endpackage

// File: rtl/bus_timeout_ctrl.sv
// Bus-error watchdog: asserts berr_n when a CPU bus cycle outlives the programmed limit,
// records the first faulting cycle and raises a level interrupt.
module bus_timeout_ctrl
  import bus_timeout_ctrl_pkg::*;
#(
  parameter logic [LIMIT_W-1:0] LIMIT_DEFAULT = LIMIT_W'(255)
) (
  input  logic              cpuclk,
  input  logic              rst_n,
  input  logic              as_n,
  input  logic              dtack_n,
  input  logic              vpa_n,
  input  logic              bg_n,
  input  logic [ADDR_W-1:0] cpu_addrbus,
  input  logic [FC_W-1:0]   cpu_fc,
  input  logic              wr_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              ctrl_wr_n,
  output logic [CTRL_W-1:0] status_out,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [FC_W-1:0]   fault_fc,
  output logic              berr_n,
  output logic              berr_int_n
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LIMIT_W-1:0] r_cnt;
  logic [LIMIT_W-1:0] r_limit;
  logic               r_en;
  logic               r_int_en;
  logic               r_fault;
  logic               r_ovr;
  logic               r_berr_n;
  logic               r_berr_int_n;
  cycle_info_t        r_shadow;
  cycle_info_t        r_fault_info;

  logic               w_start;
  logic               w_commit;
  logic               w_cfg_wr;
  logic               w_clr;
  logic               w_cnt_last;
  logic               w_fault_eff;
  logic               w_unused_ctrl;

  assign w_cfg_wr      = ~ctrl_wr_n;
  assign w_clr         = w_cfg_wr & ctrl_in[CTRL_CLR_BIT];
  assign w_cnt_last    = (r_limit != '0) && (r_cnt == (r_limit - LIMIT_W'(1)));
  // A clear on the commit edge is applied first, so the new fault is treated as the first one
  assign w_fault_eff   = r_fault & ~w_clr;
  assign w_unused_ctrl = ^ctrl_in[12:10];

  // State register
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic with cycle-start and fault-commit strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_en && !as_n && bg_n) begin
          w_state_nxt = ST_COUNT;
          w_start     = 1'b1;
        end
      end
      ST_COUNT: begin
        if (as_n)                     w_state_nxt = ST_IDLE;
        else if (!dtack_n || !vpa_n)  w_state_nxt = ST_TERM;
        else if (!r_en)               w_state_nxt = ST_IDLE;
        else if (w_cnt_last) begin
          w_state_nxt = ST_BERR;
          w_commit    = 1'b1;
        end
      end
      ST_BERR: if (as_n) w_state_nxt = ST_IDLE;
      ST_TERM: if (as_n) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Cycle-length counter, saturating in case the limit is lowered mid-cycle
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == ST_COUNT && w_state_nxt == ST_COUNT && r_cnt != '1) begin
      r_cnt <= r_cnt + LIMIT_W'(1);
    end
  end

  // Shadow capture of the cycle being watched
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n)       r_shadow <= '0;
    else if (w_start) r_shadow <= {cpu_addrbus, cpu_fc, ~wr_n};
  end

  // Configuration register
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_int_en <= 1'b0;
      r_limit  <= LIMIT_DEFAULT;
    end else if (w_cfg_wr) begin
      r_en     <= ctrl_in[CTRL_EN_BIT];
      r_int_en <= ctrl_in[CTRL_INTEN_BIT];
      r_limit  <= ctrl_in[LIMIT_W-1:0];
    end
  end

  // Fault status and interrupt; a commit overrides a same-edge clear
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_ovr        <= 1'b0;
      r_berr_int_n <= 1'b1;
      r_fault_info <= '0;
    end else begin
      if (w_clr) begin
        r_fault      <= 1'b0;
        r_ovr        <= 1'b0;
        r_berr_int_n <= 1'b1;
      end
      if (w_commit) begin
        if (!w_fault_eff) begin
          r_fault      <= 1'b1;
          r_fault_info <= r_shadow;
        end else begin
          r_ovr <= 1'b1;
        end
        if (r_int_en) r_berr_int_n <= 1'b0;
      end
    end
  end

  // Bus error drive follows the BERR state, registered
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) r_berr_n <= 1'b1;
    else        r_berr_n <= (w_state_nxt != ST_BERR);
  end

  assign status_out = {r_en, 1'b0, r_int_en, r_fault, r_ovr, r_fault_info.wr, r_limit};
  assign fault_addr = r_fault_info.addr;
  assign fault_fc   = r_fault_info.fc;
  assign berr_n     = r_berr_n;
  assign berr_int_n = r_berr_int_n;

endmodule

// File: tb/tb_bus_timeout_ctrl.sv
// Bench for bus_timeout_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_bus_timeout_ctrl;

  logic        cpuclk = 1'b0;
  logic        rst_n;
  logic        as_n, dtack_n, vpa_n, bg_n, wr_n, ctrl_wr_n;
  logic [22:0] cpu_addrbus;
  logic [2:0]  cpu_fc;
  logic [15:0] ctrl_in;
  logic [15:0] status_out;
  logic [22:0] fault_addr;
  logic [2:0]  fault_fc;
  logic        berr_n, berr_int_n;

  int n_vec = 0;
  int n_err = 0;

  bus_timeout_ctrl dut (
    .cpuclk(cpuclk), .rst_n(rst_n), .as_n(as_n), .dtack_n(dtack_n), .vpa_n(vpa_n),
    .bg_n(bg_n), .cpu_addrbus(cpu_addrbus), .cpu_fc(cpu_fc), .wr_n(wr_n),
    .ctrl_in(ctrl_in), .ctrl_wr_n(ctrl_wr_n), .status_out(status_out),
    .fault_addr(fault_addr), .fault_fc(fault_fc), .berr_n(berr_n), .berr_int_n(berr_int_n)
  );

  always #5 cpuclk = ~cpuclk;

  // ---------------- behavioural model ----------------
  // phase: 0 no cycle watched, 1 watching, 2 bus error driven, 3 terminated/waiting for AS high
  typedef struct {
    int          phase;
    int          age;       // edges elapsed since the cycle was first seen
    logic [22:0] sh_addr;
    logic [2:0]  sh_fc;
    logic        sh_wr;
    logic        en, int_en;
    int          limit;
    logic        fault, ovr, fwr;
    logic [22:0] faddr;
    logic [2:0]  ffc;
    logic        irq;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0; r.age = 0; r.sh_addr = '0; r.sh_fc = '0; r.sh_wr = 1'b0;
    r.en = 1'b0; r.int_en = 1'b0; r.limit = 255;
    r.fault = 1'b0; r.ovr = 1'b0; r.fwr = 1'b0; r.faddr = '0; r.ffc = '0; r.irq = 1'b0;
    return r;
  endfunction

  function automatic model_t step(model_t s);
    model_t n = s;
    bit     timed_out = 0;
    bit     clr = (!ctrl_wr_n) && ctrl_in[14];
    case (s.phase)
      0: if (s.en && !as_n && bg_n) begin
           n.phase = 1; n.age = 0;
           n.sh_addr = cpu_addrbus; n.sh_fc = cpu_fc; n.sh_wr = !wr_n;
         end
      1: begin
           if (as_n)                     n.phase = 0;
           else if (!dtack_n || !vpa_n)  n.phase = 3;
           else if (!s.en)               n.phase = 0;
           else begin
             n.age = s.age + 1;
             if (n.age == s.limit) begin n.phase = 2; timed_out = 1; end
           end
         end
      default: if (as_n) n.phase = 0;
    endcase
    if (!ctrl_wr_n) begin
      n.en = ctrl_in[15]; n.int_en = ctrl_in[13]; n.limit = int'(ctrl_in[9:0]);
    end
    if (clr) begin n.fault = 0; n.ovr = 0; n.irq = 0; end
    if (timed_out) begin
      if (s.fault && !clr) n.ovr = 1;
      else begin
        n.fault = 1; n.faddr = s.sh_addr; n.ffc = s.sh_fc; n.fwr = s.sh_wr;
      end
      if (s.int_en) n.irq = 1;
    end
    return n;
  endfunction

  always @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge cpuclk) begin
    if (rst_n === 1'b1) begin
      check("mdl_berr_n",     32'(berr_n),     32'(!(m.phase == 2)));
      check("mdl_berr_int_n", 32'(berr_int_n), 32'(!m.irq));
      check("mdl_status",     32'(status_out),
            32'({m.en, 1'b0, m.int_en, m.fault, m.ovr, m.fwr, 10'(m.limit)}));
      check("mdl_fault_addr", 32'(fault_addr), 32'(m.faddr));
      check("mdl_fault_fc",   32'(fault_fc),   32'(m.ffc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge cpuclk);
  endtask

  task automatic cfg_write(input logic [15:0] v);
    @(negedge cpuclk);
    ctrl_in = v; ctrl_wr_n = 1'b0;
    @(negedge cpuclk);
    ctrl_wr_n = 1'b1;
  endtask

  task automatic start_cycle(input logic [22:0] a, input logic [2:0] fc, input logic wr);
    @(negedge cpuclk);
    cpu_addrbus = a; cpu_fc = fc; wr_n = ~wr; as_n = 1'b0;
  endtask

  task automatic end_cycle();
    @(negedge cpuclk);
    as_n = 1'b1; dtack_n = 1'b1; vpa_n = 1'b1;
  endtask

  // Full timed-out cycle at limit 8: berr low after the 8th edge, then AS released
  task automatic fault_cycle(input logic [22:0] a, input logic [2:0] fc, input logic wr);
    start_cycle(a, fc, wr);
    tick(9);
    check("fc_berr_low", 32'(berr_n), 32'(0));
    end_cycle();
    tick(1);
    check("fc_berr_rel", 32'(berr_n), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; as_n = 1'b1; dtack_n = 1'b1; vpa_n = 1'b1; bg_n = 1'b1;
    cpu_addrbus = '0; cpu_fc = '0; wr_n = 1'b1; ctrl_in = '0; ctrl_wr_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_status", 32'(status_out), 32'h00FF);
    check("rst_berr_n", 32'(berr_n), 32'(1));
    check("rst_int_n",  32'(berr_int_n), 32'(1));

    // 1: basic timeout, exact latency
    cfg_write(16'h8008);
    start_cycle(23'h7FFFF0, 3'd5, 1'b0);
    tick(8);
    check("t1_berr_before", 32'(berr_n), 32'(1));
    tick(1);
    check("t1_berr_at_limit", 32'(berr_n), 32'(0));
    check("t1_status", 32'(status_out), 32'h9008);
    check("t1_addr", 32'(fault_addr), 32'h7FFFF0);
    check("t1_fc", 32'(fault_fc), 32'd5);
    tick(3);
    check("t1_berr_held", 32'(berr_n), 32'(0));
    end_cycle();
    tick(1);
    check("t1_berr_release", 32'(berr_n), 32'(1));
    cfg_write(16'hC008);
    check("t1_clr", 32'(status_out), 32'h8008);

    // 2: DTACK terminates, AS release without termination
    start_cycle(23'h123456, 3'd2, 1'b0);
    tick(3);
    dtack_n = 1'b0;
    tick(12);
    check("t2_dtack_no_berr", 32'(berr_n), 32'(1));
    end_cycle();
    tick(2);
    start_cycle(23'h000100, 3'd6, 1'b1);
    tick(5);
    end_cycle();
    tick(10);
    check("t2_no_fault", 32'(status_out), 32'h8008);

    // 3: two faults -> overrun, first kept; then clear
    fault_cycle(23'h100000, 3'd1, 1'b1);
    fault_cycle(23'h200000, 3'd6, 1'b0);
    check("t3_status_ovr", 32'(status_out), 32'h9C08);
    check("t3_addr_kept", 32'(fault_addr), 32'h100000);
    check("t3_fc_kept", 32'(fault_fc), 32'd1);
    cfg_write(16'hC008);
    check("t3_clr_status", 32'(status_out), 32'h8408);
    check("t3_clr_int", 32'(berr_int_n), 32'(1));

    // 4: clear on the commit edge loses to the commit
    cfg_write(16'hA008);
    start_cycle(23'h0ABCDE, 3'd3, 1'b0);
    tick(7);
    cfg_write(16'hE008);
    check("t4_same_edge_berr", 32'(berr_n), 32'(0));
    check("t4_same_edge_status", 32'(status_out), 32'hB008);
    check("t4_same_edge_int", 32'(berr_int_n), 32'(0));
    check("t4_same_edge_addr", 32'(fault_addr), 32'h0ABCDE);
    end_cycle();
    tick(1);
    cfg_write(16'hC008);
    check("t4_clr_int", 32'(berr_int_n), 32'(1));
    fault_cycle(23'h0F0F0F, 3'd4, 1'b0);
    check("t4_noint_int", 32'(berr_int_n), 32'(1));
    check("t4_noint_status", 32'(status_out), 32'h9008);
    cfg_write(16'hA008);
    fault_cycle(23'h070707, 3'd2, 1'b1);
    check("t4_ovr_int", 32'(berr_int_n), 32'(0));
    cfg_write(16'h8008);
    check("t4_int_sticky", 32'(berr_int_n), 32'(0));
    check("t4_int_sticky_st", 32'(status_out), 32'h9808);
    cfg_write(16'hC008);
    check("t4_final_clr", 32'(berr_int_n), 32'(1));

    // 5: limit 0 and bus granted away never time out; disable mid-count
    cfg_write(16'hC000);
    start_cycle(23'h012345, 3'd5, 1'b0);
    tick(2000);
    check("t5_lim0_berr", 32'(berr_n), 32'(1));
    check("t5_lim0_status", 32'(status_out), 32'h8000);
    end_cycle();
    tick(1);
    cfg_write(16'h8008);
    bg_n = 1'b0;
    start_cycle(23'h054321, 3'd5, 1'b0);
    tick(2000);
    check("t5_bg_berr", 32'(berr_n), 32'(1));
    end_cycle();
    tick(1);
    bg_n = 1'b1;
    start_cycle(23'h066666, 3'd1, 1'b0);
    tick(3);
    cfg_write(16'h0008);
    tick(10);
    check("t5_dis_berr", 32'(berr_n), 32'(1));
    end_cycle();
    tick(1);
    check("t5_dis_status", 32'(status_out), 32'h0008);

    // 6: reset while berr_n is low
    cfg_write(16'hA008);
    start_cycle(23'h555555, 3'd7, 1'b1);
    tick(9);
    check("t6_berr_low", 32'(berr_n), 32'(0));
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_berr", 32'(berr_n), 32'(1));
    check("t6_rst_int", 32'(berr_int_n), 32'(1));
    check("t6_rst_status", 32'(status_out), 32'h00FF);
    check("t6_rst_addr", 32'(fault_addr), 32'h0);
    check("t6_rst_fc", 32'(fault_fc), 32'h0);
    @(negedge cpuclk);
    rst_n = 1'b1;
    as_n = 1'b1;
    tick(3);
    check("t6_post_status", 32'(status_out), 32'h00FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
